comp_mul: RTL and testbench

Sequential unsigned shift-add multiplier. It is the companion to the team's sequential restoring divider and uses the same run/ready handshake, so the two can sit side by side in the ALU datapath.
- Takes two WIDTH-bit operands and produces a 2*WIDTH-bit product.
- Performs one add/shift iteration per clock and has fixed latency.
- Holds the completed product stable for the consumer until the next operation is accepted.

---
 rtl/comp_mul.sv | 74 +++++++
 tb/tb_comp_mul.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/comp_mul.sv
// Sequential unsigned shift-add multiplier: one add/shift step per clock,
// WIDTH steps per product, result held until the next operation is accepted.
module comp_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [WIDTH-1:0]     Multiplicand_input,
  input  logic [WIDTH-1:0]     Multiplier_input,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   Product_output
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_next;
  logic               last;

  // acc[2*WIDTH] is always zero between steps, so using it as the sum's top
  // bit is equivalent to zero-extending the upper half before the add.
  always_comb begin
    sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    end
    acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    last     = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      mcand          <= '0;
      acc            <= '0;
      cnt            <= '0;
      Product_output <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (run) begin
            mcand <= Multiplicand_input;
            acc   <= {{(WIDTH+1){1'b0}}, Multiplier_input};
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            Product_output <= acc_next[2*WIDTH-1:0];
            state          <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == CALC);
  assign ready = (state == DONE);

endmodule

// File: tb/tb_comp_mul.sv
// Directed bench for comp_mul (WIDTH=32) with hand-computed products,
// latency checks, run-ignored-in-CALC, back-to-back and mid-operation reset.
module tb_comp_mul;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        ready;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;
  int cycles;
  int busy_cycles;

  always #5 clk = ~clk;

  comp_mul #(.WIDTH(WIDTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .run                (run),
    .Multiplicand_input (a),
    .Multiplier_input   (b),
    .busy               (busy),
    .ready              (ready),
    .Product_output     (prod)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents operands for exactly one rising edge, then scrambles them so a
  // design that re-reads its inputs during CALC produces a wrong product.
  task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a   = x;
    b   = y;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    a   = $urandom;
    b   = $urandom;
  endtask

  task automatic wait_ready(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    while (!ready && n < 200) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] expected);
    apply_stimulus(x, y);
    wait_ready(cycles, busy_cycles);
    check_output({tag, "_latency"}, 64'(cycles), 64'd32);
    check_output({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd32);
    check_output({tag, "_product"}, prod, expected);
    check_output({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    run = 1'b0;
    a   = '0;
    b   = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_ready", 64'(ready), 64'd0);
    check_output("reset_product", prod, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_case("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    repeat (10) @(negedge clk);
    check_output("hold_3x5_product", prod, 64'h0000_0000_0000_000F);
    check_output("hold_3x5_ready", 64'(ready), 64'd1);

    run_case("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_case("mul_msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    run_case("mul_zero", 32'd0, 32'h1234_5678, 64'd0);

    // run pulsed with other operands at iteration 10 must be ignored
    apply_stimulus(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    a   = 32'd100;
    b   = 32'd100;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_ready(cycles, busy_cycles);
    check_output("ignore_run_latency", 64'(cycles), 64'd22);
    check_output("ignore_run_product", prod, 64'd63);
    repeat (5) @(negedge clk);
    check_output("ignore_run_still_done", 64'(ready), 64'd1);
    check_output("ignore_run_not_busy", 64'(busy), 64'd0);
    check_output("ignore_run_held", prod, 64'd63);

    run_case("mul_6x7", 32'd6, 32'd7, 64'd42);
    apply_stimulus(32'd12, 32'd12);
    check_output("b2b_ready_drop", 64'(ready), 64'd0);
    check_output("b2b_busy_rise", 64'(busy), 64'd1);
    check_output("b2b_product_kept", prod, 64'd42);
    repeat (15) @(negedge clk);
    check_output("b2b_product_mid", prod, 64'd42);
    wait_ready(cycles, busy_cycles);
    check_output("b2b_latency", 64'(cycles), 64'd17);
    check_output("b2b_product", prod, 64'd144);

    // asynchronous reset in the middle of a clock period, mid-operation
    apply_stimulus(32'd1000, 32'd1000);
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("midop_reset_busy", 64'(busy), 64'd0);
    check_output("midop_reset_ready", 64'(ready), 64'd0);
    check_output("midop_reset_product", prod, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_reset_idle_busy", 64'(busy), 64'd0);
    check_output("post_reset_idle_ready", 64'(ready), 64'd0);
    check_output("post_reset_product", prod, 64'd0);

    run_case("mul_2x3", 32'd2, 32'd3, 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
